// File: rtl/quic_dec_golomb.sv
// Golomb-Rice symbol decoder: buffers an MSB-first 32-bit word stream and
// decodes one GR / escape-coded symbol per request using the family table.
`ifndef QUIC_DEC_SET
`define QUIC_DEC_SET 3'd1
`endif

module quic_dec_golomb #(
  parameter int unsigned BUF_W = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  quic_dec_state,
  input  logic        word_valid,
  input  logic [31:0] word_data,
  output logic        word_ready,
  input  logic        sym_req,
  input  logic [2:0]  bestcode,
  output logic [2:0]  bestcode_o,
  input  logic [31:0] nGRcodewords_i,
  input  logic [31:0] notGRcwlen_i,
  input  logic [31:0] notGRprefixmask_i,
  input  logic [31:0] notGRsuffixlen_i,
  output logic        busy,
  output logic        sym_valid,
  output logic [15:0] sym_data,
  output logic [5:0]  sym_len
);

  typedef enum logic [1:0] {IDLE, FILL, CALC, OUT} state_t;

  state_t           state;
  logic [BUF_W-1:0] bitBuf;
  logic [BUF_W-1:0] bufShift;
  logic [BUF_W-1:0] bufNext;
  logic [6:0]       fill;
  logic [6:0]       fillShift;
  logic [6:0]       fillNext;
  logic             flush;
  logic             accept;
  logic             consume;

  logic [31:0]      win;
  logic             gr;
  logic [4:0]       zp;
  logic [5:0]       grLen;
  logic [5:0]       cwlen;
  logic [5:0]       shAmt;
  logic [31:0]      tail;
  logic [31:0]      grMask;
  logic [31:0]      ngMask;
  logic [31:0]      sym;
  logic             unusedBits;

  assign flush      = (quic_dec_state == `QUIC_DEC_SET);
  assign word_ready = !reset && !flush && (fill <= 7'd32);
  assign accept     = word_valid && word_ready;
  assign consume    = (state == OUT);

  assign unusedBits = ^{nGRcodewords_i[31:16], notGRcwlen_i[31:6],
                        notGRsuffixlen_i[31:4], sym[31:16]};

  // Consume happens first so a same-cycle word lands right after the
  // surviving bits; invariant: bits below fill are always zero.
  always_comb begin
    bufShift  = bitBuf;
    fillShift = fill;
    if (consume) begin
      bufShift  = bitBuf << sym_len;
      fillShift = fill - {1'b0, sym_len};
    end
    bufNext  = bufShift;
    fillNext = fillShift;
    if (accept) begin
      bufNext  = bufShift | ({word_data, {(BUF_W-32){1'b0}}} >> fillShift);
      fillNext = fillShift + 7'd32;
    end
  end

  always_comb begin
    win = bitBuf[BUF_W-1 -: 32];
    gr  = (win > notGRprefixmask_i);
    zp  = 5'd31;
    for (int unsigned i = 0; i < 32; i++) begin
      if (win[i]) zp = 5'(31 - i);
    end
    grLen  = {1'b0, zp} + 6'd1 + {3'b000, bestcode_o};
    cwlen  = gr ? grLen : notGRcwlen_i[5:0];
    shAmt  = 6'd32 - cwlen;
    tail   = win >> shAmt;
    grMask = (32'd1 << bestcode_o) - 32'd1;
    ngMask = (32'd1 << notGRsuffixlen_i[3:0]) - 32'd1;
    if (gr) sym = ({27'd0, zp} << bestcode_o) | (tail & grMask);
    else    sym = {16'd0, nGRcodewords_i[15:0]} + (tail & ngMask);
  end

  // Symbol is evaluated from the live window in CALC so the output
  // registers are valid during OUT; OUT then consumes sym_len bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bitBuf     <= '0;
      fill       <= '0;
      busy       <= 1'b0;
      sym_valid  <= 1'b0;
      sym_data   <= '0;
      sym_len    <= '0;
      bestcode_o <= '0;
    end else begin
      sym_valid <= 1'b0;
      if (flush) begin
        state  <= IDLE;
        bitBuf <= '0;
        fill   <= '0;
        busy   <= 1'b0;
      end else begin
        bitBuf <= bufNext;
        fill   <= fillNext;
        case (state)
          IDLE: begin
            if (sym_req) begin
              bestcode_o <= bestcode;
              busy       <= 1'b1;
              state      <= (fill < 7'd32) ? FILL : CALC;
            end
          end
          FILL: begin
            if (fill >= 7'd32) state <= CALC;
          end
          CALC: begin
            sym_data  <= sym[15:0];
            sym_len   <= cwlen;
            sym_valid <= 1'b1;
            state     <= OUT;
          end
          OUT: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
